llc_lookup_stage: RTL and testbench

//  Pipeline stage between the local-memory read FIFO and the process stage of the LLC.

---
 rtl/llc_pkg.sv | 20 ++
 rtl/llc_way_select.sv | 62 ++++++
 rtl/llc_lookup_stage.sv | 109 ++++++++++
 tb/tb_llc_lookup_stage.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/llc_pkg.sv
// rtl/llc_pkg.sv - shared widths, state encoding and lookup result type for the LLC lookup stage
package llc_pkg;

  localparam int LLC_WAYS       = 16;
  localparam int LLC_WAY_BITS   = 4;
  localparam int LLC_TAG_BITS   = 15;
  localparam int LLC_STATE_BITS = 3;
  localparam int LLC_CTRL_BITS  = 7;

  localparam logic [LLC_STATE_BITS-1:0] LLC_STATE_INVALID = '0;

  typedef struct packed {
    logic [LLC_WAY_BITS-1:0]  way;
    logic                     hit;
    logic                     empty;
    logic                     evict;
    logic [LLC_CTRL_BITS-1:0] ctrl;
  } llc_result_t;

endpackage

// File: rtl/llc_way_select.sv
// rtl/llc_way_select.sv - combinational hit / rotating empty / evict way selection
module llc_way_select
  import llc_pkg::*;
#(
  parameter int WAYS       = LLC_WAYS,
  parameter int WAY_BITS   = LLC_WAY_BITS,
  parameter int TAG_BITS   = LLC_TAG_BITS,
  parameter int STATE_BITS = LLC_STATE_BITS,
  parameter int CTRL_BITS  = LLC_CTRL_BITS
) (
  input  logic [TAG_BITS-1:0]        in_tag,
  input  logic [WAYS*TAG_BITS-1:0]   in_tags,
  input  logic [WAYS*STATE_BITS-1:0] in_states,
  input  logic [WAY_BITS-1:0]        in_evict_way,
  input  logic [CTRL_BITS-1:0]       in_ctrl,
  output llc_result_t                res
);

  logic                hit_found;
  logic                empty_found;
  logic [WAY_BITS-1:0] hit_way;
  logic [WAY_BITS-1:0] empty_way;
  logic [WAY_BITS-1:0] idx;

  // Lowest matching valid way wins a hit; otherwise the first INVALID way
  // starting at the evict pointer (wrapping) is filled; otherwise evict.
  always_comb begin
    res         = '0;
    hit_found   = 1'b0;
    empty_found = 1'b0;
    hit_way     = '0;
    empty_way   = '0;
    idx         = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (!hit_found &&
          in_tags[i*TAG_BITS +: TAG_BITS] == in_tag &&
          in_states[i*STATE_BITS +: STATE_BITS] != LLC_STATE_INVALID) begin
        hit_found = 1'b1;
        hit_way   = WAY_BITS'(i);
      end
    end
    for (int k = 0; k < WAYS; k++) begin
      idx = in_evict_way + WAY_BITS'(k);
      if (!empty_found && in_states[idx*STATE_BITS +: STATE_BITS] == LLC_STATE_INVALID) begin
        empty_found = 1'b1;
        empty_way   = idx;
      end
    end
    res.ctrl = in_ctrl;
    if (hit_found) begin
      res.way = hit_way;
      res.hit = 1'b1;
    end else if (empty_found) begin
      res.way   = empty_way;
      res.empty = 1'b1;
    end else begin
      res.way   = in_evict_way;
      res.evict = 1'b1;
    end
  end

endmodule

// File: rtl/llc_lookup_stage.sv
// rtl/llc_lookup_stage.sv - registered LLC lookup stage with 2-entry skid buffer and hit/miss counters
module llc_lookup_stage
  import llc_pkg::*;
#(
  parameter int WAYS       = LLC_WAYS,
  parameter int WAY_BITS   = LLC_WAY_BITS,
  parameter int TAG_BITS   = LLC_TAG_BITS,
  parameter int STATE_BITS = LLC_STATE_BITS,
  parameter int CTRL_BITS  = LLC_CTRL_BITS
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [TAG_BITS-1:0]         in_tag,
  input  logic [WAYS*TAG_BITS-1:0]    in_tags,
  input  logic [WAYS*STATE_BITS-1:0]  in_states,
  input  logic [WAY_BITS-1:0]         in_evict_way,
  input  logic [CTRL_BITS-1:0]        in_ctrl,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WAY_BITS-1:0]         out_way,
  output logic                        out_hit,
  output logic                        out_empty,
  output logic                        out_evict,
  output logic [CTRL_BITS-1:0]        out_ctrl,
  output logic [15:0]                 hit_cnt,
  output logic [15:0]                 miss_cnt
);

  llc_result_t lookup;
  llc_result_t main_res;
  llc_result_t skid_res;
  logic        main_valid;
  logic        skid_valid;
  logic        accept;
  logic        out_fire;

  llc_way_select #(
    .WAYS       (WAYS),
    .WAY_BITS   (WAY_BITS),
    .TAG_BITS   (TAG_BITS),
    .STATE_BITS (STATE_BITS),
    .CTRL_BITS  (CTRL_BITS)
  ) u_way_select (
    .in_tag       (in_tag),
    .in_tags      (in_tags),
    .in_states    (in_states),
    .in_evict_way (in_evict_way),
    .in_ctrl      (in_ctrl),
    .res          (lookup)
  );

  // in_ready comes straight from the skid flag so it never depends on out_ready.
  assign in_ready  = !skid_valid;
  assign accept    = in_valid && in_ready;
  assign out_fire  = main_valid && out_ready;

  assign out_valid = main_valid;
  assign out_way   = main_res.way;
  assign out_hit   = main_res.hit;
  assign out_empty = main_res.empty;
  assign out_evict = main_res.evict;
  assign out_ctrl  = main_res.ctrl;

  // Main/skid slot update; flush wins over everything, skid refills main first.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_res   <= '0;
      skid_res   <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (skid_valid) begin
      if (out_ready) begin
        main_res   <= skid_res;
        skid_valid <= 1'b0;
      end
    end else if (accept) begin
      if (!main_valid || out_ready) begin
        main_res   <= lookup;
        main_valid <= 1'b1;
      end else begin
        skid_res   <= lookup;
        skid_valid <= 1'b1;
      end
    end else if (out_fire) begin
      main_valid <= 1'b0;
    end
  end

  // Saturating hit/miss counters, bumped on each output handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (out_fire) begin
      if (main_res.hit) begin
        if (hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
      end else begin
        if (miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_llc_lookup_stage.sv
// tb/tb_llc_lookup_stage.sv - directed self-checking bench for llc_lookup_stage
module tb_llc_lookup_stage;

  logic         clk;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [14:0]  in_tag;
  logic [239:0] in_tags;
  logic [47:0]  in_states;
  logic [3:0]   in_evict_way;
  logic [6:0]   in_ctrl;
  logic         out_valid;
  logic         out_ready;
  logic [3:0]   out_way;
  logic         out_hit;
  logic         out_empty;
  logic         out_evict;
  logic [6:0]   out_ctrl;
  logic [15:0]  hit_cnt;
  logic [15:0]  miss_cnt;

  logic [14:0]  t [16];
  logic [2:0]   s [16];
  int           n_cmp;
  int           n_err;
  int           exp_hit;
  int           exp_miss;

  llc_lookup_stage dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_tag       (in_tag),
    .in_tags      (in_tags),
    .in_states    (in_states),
    .in_evict_way (in_evict_way),
    .in_ctrl      (in_ctrl),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_way      (out_way),
    .out_hit      (out_hit),
    .out_empty    (out_empty),
    .out_evict    (out_evict),
    .out_ctrl     (out_ctrl),
    .hit_cnt      (hit_cnt),
    .miss_cnt     (miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // every way VALID with a tag that never equals the request tags used below
  task automatic fill_nomatch;
    for (int i = 0; i < 16; i++) begin
      t[i] = 15'h100 + 15'(i);
      s[i] = 3'd1;
    end
  endtask

  task automatic apply(input logic [14:0] tag, input logic [3:0] ev, input logic [6:0] ctrl);
    for (int i = 0; i < 16; i++) begin
      in_tags[i*15 +: 15] = t[i];
      in_states[i*3 +: 3] = s[i];
    end
    in_tag       = tag;
    in_evict_way = ev;
    in_ctrl      = ctrl;
  endtask

  // {out_way, hit, empty, evict, ctrl} packed for one-shot result comparison
  function automatic logic [31:0] res(input logic [3:0] w, input logic h, input logic e,
                                      input logic v, input logic [6:0] c);
    return {17'd0, w, h, e, v, c};
  endfunction

  function automatic logic [31:0] obs();
    return {17'd0, out_way, out_hit, out_empty, out_evict, out_ctrl};
  endfunction

  initial begin
    n_cmp = 0; n_err = 0; exp_hit = 0; exp_miss = 0;
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_tag = '0; in_tags = '0; in_states = '0; in_evict_way = '0; in_ctrl = '0;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_result", obs(), 0);
    check("rst_cnts", {hit_cnt, miss_cnt}, 0);
    #10 rst = 1'b1;
    tick;

    // hit: tag 0x12 valid in way 5, also present in INVALID way 3
    for (int i = 0; i < 16; i++) begin t[i] = 15'(i); s[i] = 3'd0; end
    t[5] = 15'h12; s[5] = 3'd1; t[3] = 15'h12;
    apply(15'h12, 4'd0, 7'h55);
    in_valid = 1'b1; out_ready = 1'b1;
    tick;
    in_valid = 1'b0;
    check("hit_valid", out_valid, 1);
    check("hit_result", obs(), res(4'd5, 1, 0, 0, 7'h55));
    tick;
    exp_hit++;
    check("hit_cnt", hit_cnt, 32'(exp_hit));
    check("hit_drained", out_valid, 0);

    // all valid, no match, evict pointer 9
    fill_nomatch;
    apply(15'h12, 4'd9, 7'h0A);
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    check("evict_result", obs(), res(4'd9, 0, 0, 1, 7'h0A));
    tick;
    exp_miss++;
    check("evict_miss_cnt", miss_cnt, 32'(exp_miss));

    // ways 2 and 11 INVALID, scan from 6 lands on 11; from 12 wraps to 2
    s[2] = 3'd0; s[11] = 3'd0;
    apply(15'h12, 4'd6, 7'h33);
    in_valid = 1'b1;
    tick;
    check("empty_scan6", obs(), res(4'd11, 0, 1, 0, 7'h33));
    apply(15'h12, 4'd12, 7'h34);
    tick;
    check("empty_wrap12", obs(), res(4'd2, 0, 1, 0, 7'h34));
    // hit takes priority over an INVALID way
    t[7] = 15'h12;
    apply(15'h12, 4'd0, 7'h35);
    tick;
    in_valid = 1'b0;
    check("hit_over_empty", obs(), res(4'd7, 1, 0, 0, 7'h35));
    tick;
    exp_miss += 2; exp_hit++;
    check("cnts_after_mix", {hit_cnt, miss_cnt}, {16'(exp_hit), 16'(exp_miss)});

    // back-pressure: A (hit way 7) then B (evict way 9) while out_ready=0
    out_ready = 1'b0;
    s[2] = 3'd1; s[11] = 3'd1;
    apply(15'h12, 4'd0, 7'h11);
    in_valid = 1'b1;
    tick;
    t[7] = 15'h107;
    apply(15'h12, 4'd9, 7'h22);
    tick;
    check("skid_in_ready", in_ready, 0);
    check("skid_main_A", obs(), res(4'd7, 1, 0, 0, 7'h11));
    apply(15'h12, 4'd3, 7'h44);
    tick;
    in_valid = 1'b0;
    check("skid_stable", obs(), res(4'd7, 1, 0, 0, 7'h11));
    check("skid_stable_rdy", in_ready, 0);
    out_ready = 1'b1;
    tick;
    check("skid_drain_B", obs(), res(4'd9, 0, 0, 1, 7'h22));
    check("skid_rdy_back", {out_valid, in_ready}, 2'b11);
    tick;
    exp_hit++; exp_miss++;
    check("skid_empty", out_valid, 0);
    check("skid_cnts", {hit_cnt, miss_cnt}, {16'(exp_hit), 16'(exp_miss)});

    // back-to-back stream, one result per cycle, latency 1
    fill_nomatch;
    in_valid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      apply(15'h7FFF, 4'(k % 16), 7'(k));
      tick;
      check("b2b", {out_valid, in_ready, obs()},
            {2'b11, res(4'(k % 16), 0, 0, 1, 7'(k))});
    end
    in_valid = 1'b0;
    tick;
    exp_miss += 100;
    check("b2b_done", out_valid, 0);
    check("b2b_miss_cnt", miss_cnt, 32'(exp_miss));

    // flush with only main full: the same-cycle accept is dropped
    out_ready = 1'b0;
    apply(15'h7FFF, 4'd1, 7'h61);
    in_valid = 1'b1;
    tick;
    flush = 1'b1;
    apply(15'h7FFF, 4'd2, 7'h62);
    tick;
    flush = 1'b0; in_valid = 1'b0;
    check("flush1_empty", {out_valid, in_ready}, 2'b01);

    // flush with both slots full plus an offered packet
    in_valid = 1'b1;
    apply(15'h7FFF, 4'd3, 7'h63);
    tick;
    apply(15'h7FFF, 4'd4, 7'h64);
    tick;
    check("flush2_full", {out_valid, in_ready}, 2'b10);
    flush = 1'b1;
    tick;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    check("flush2_empty", {out_valid, in_ready}, 2'b01);
    tick; tick;
    check("flush2_nothing", out_valid, 0);
    check("flush_cnts", {hit_cnt, miss_cnt}, {16'(exp_hit), 16'(exp_miss)});

    // asynchronous reset with both slots full, asserted between edges
    out_ready = 1'b0; in_valid = 1'b1;
    apply(15'h7FFF, 4'd5, 7'h65);
    tick;
    apply(15'h7FFF, 4'd6, 7'h66);
    tick;
    in_valid = 1'b0;
    #3 rst = 1'b0;
    #1;
    exp_hit = 0; exp_miss = 0;
    check("arst_outs", {out_valid, in_ready, obs()}, {2'b01, 32'd0});
    check("arst_cnts", {hit_cnt, miss_cnt}, 0);
    #2 rst = 1'b1;
    out_ready = 1'b1;
    tick; tick;
    check("arst_nothing", out_valid, 0);

    // stage works again after reset
    t[4] = 15'h12;
    apply(15'h12, 4'd0, 7'h7F);
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    check("post_rst_hit", obs(), res(4'd4, 1, 0, 0, 7'h7F));
    tick;
    exp_hit++;
    check("post_rst_cnts", {hit_cnt, miss_cnt}, {16'(exp_hit), 16'(exp_miss)});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
